// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: state encoding,
// default widths and a busy decode helper.
package cnt_ctrl_pkg;

    localparam int W_DEF  = 4;
    localparam int WC_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/cnt_sync.sv
// Synchronous W-bit up-counter with active-low reset, synchronous clear and
// count enable; clear takes priority over enable.
module cnt_sync #(
    parameter int W = 4
) (
    input  logic         ck,
    input  logic         res,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge ck) begin
        if (!res) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cnt16_ctrl.sv
// Sequencing controller for a W-bit counter: start/pause/resume/clear,
// programmable terminal count, one-shot or auto-reload with a wrap tally.
module cnt16_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int WC = WC_DEF
) (
    input  logic          ck,
    input  logic          res,
    input  logic          start,
    input  logic          stop,
    input  logic          clr,
    input  logic          mode_auto,
    input  logic [W-1:0]  limit,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic [WC-1:0] wraps
);

    localparam logic [WC-1:0] WRAPS_MAX = '1;

    state_t        state;
    logic [W-1:0]  limit_r;
    logic          auto_r;
    logic          terminal;
    logic          go;
    logic          cnt_en;
    logic          cnt_clr;

    assign terminal = (q == limit_r);
    // stop outranks start everywhere, so a begin/resume needs stop low
    assign go       = start && !stop;
    assign busy     = state_is_busy(state);

    always_comb begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        if (clr) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: cnt_clr = go;
                ST_RUN: begin
                    if (!stop) begin
                        if (!terminal) begin
                            cnt_en = 1'b1;
                        end else if (auto_r) begin
                            cnt_clr = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    cnt_sync #(.W(W)) u_cnt (
        .ck  (ck),
        .res (res),
        .clr (cnt_clr),
        .en  (cnt_en),
        .q   (q)
    );

    always_ff @(posedge ck) begin
        if (!res) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            wraps   <= '0;
            limit_r <= '1;
            auto_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                // wraps deliberately survives an abort until the next start
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (go) begin
                            state   <= ST_RUN;
                            limit_r <= limit;
                            auto_r  <= mode_auto;
                            wraps   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state <= ST_HOLD;
                        end else if (terminal) begin
                            done <= 1'b1;
                            if (auto_r) begin
                                if (wraps != WRAPS_MAX) begin
                                    wraps <= wraps + 1'b1;
                                end
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (go) begin
                            state <= ST_RUN;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt16_ctrl.sv
// Self-checking bench for cnt16_ctrl: directed scenarios plus randomized
// traffic, all compared against a flag-based behavioural model.
module tb_cnt16_ctrl;

    localparam int W  = 4;
    localparam int WC = 4;
    localparam int QMAX = (1 << W) - 1;
    localparam int WMAX = (1 << WC) - 1;

    logic          ck = 1'b0;
    logic          res = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clr = 1'b0;
    logic          mode_auto = 1'b0;
    logic [W-1:0]  limit = '0;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic [WC-1:0] wraps;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model: counting / paused flags instead of a state machine
    bit m_counting, m_paused, m_done, m_auto;
    int m_q, m_lim, m_wraps;

    always #5 ck = ~ck;

    cnt16_ctrl #(.W(W), .WC(WC)) dut (
        .ck        (ck),
        .res       (res),
        .start     (start),
        .stop      (stop),
        .clr       (clr),
        .mode_auto (mode_auto),
        .limit     (limit),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wraps     (wraps)
    );

    task automatic model_step();
        if (!res) begin
            m_counting = 0; m_paused = 0; m_done = 0; m_q = 0;
            m_lim = QMAX; m_auto = 0; m_wraps = 0;
        end else if (clr) begin
            m_counting = 0; m_paused = 0; m_done = 0; m_q = 0;
        end else if (m_counting && !m_paused) begin
            m_done = 0;
            if (stop) begin
                m_paused = 1;
            end else if (m_q == m_lim) begin
                m_done = 1;
                if (m_auto) begin
                    m_q = 0;
                    if (m_wraps < WMAX) m_wraps++;
                end else begin
                    m_counting = 0;
                end
            end else begin
                m_q = (m_q + 1) % (QMAX + 1);
            end
        end else if (m_paused) begin
            m_done = 0;
            if (start && !stop) m_paused = 0;
        end else begin
            m_done = 0;
            if (start && !stop) begin
                m_counting = 1; m_lim = int'(limit); m_auto = mode_auto;
                m_q = 0; m_wraps = 0;
            end
        end
    endtask

    function automatic logic [W+WC+1:0] model_vec();
        return {W'(m_q), m_counting, m_done, WC'(m_wraps)};
    endfunction

    task automatic tick();
        @(posedge ck);
        model_step();
        #1;
    endtask

    task automatic drive(input bit s, input bit p, input bit c, input bit m, input int l);
        start = s; stop = p; clr = c; mode_auto = m; limit = W'(l);
    endtask

    task automatic test_reset();
        res = 0; drive(1, 0, 0, 1, 5);
        tick(); tick();
        n_checks++;
        if ({q, busy, done, wraps} !== '0)
            $display("FAIL reset_vals q=%0d busy=%b done=%b wraps=%0d required all zero", q, busy, done, wraps);
        else n_pass++;
        res = 1; drive(0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({q, busy, done, wraps} !== model_vec() || busy !== 1'b0)
            $display("FAIL reset_release got=%h required=%h", {q, busy, done, wraps}, model_vec());
        else n_pass++;
    endtask

    task automatic test_oneshot();
        int exp_q [7] = '{0, 1, 2, 3, 4, 5, 5};
        drive(1, 0, 0, 0, 5);
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(0, 0, 0, 0, 5);
            n_checks++;
            if ({q, busy, done, wraps} !== model_vec())
                $display("FAIL oneshot_model step=%0d got=%h required=%h", i, {q, busy, done, wraps}, model_vec());
            else n_pass++;
            if (i < 7) begin
                n_checks++;
                if (q !== W'(exp_q[i]) || done !== (i == 6) || busy !== (i < 6))
                    $display("FAIL oneshot_seq step=%0d q=%0d done=%b busy=%b required q=%0d done=%b busy=%b",
                             i, q, done, busy, exp_q[i], i == 6, i < 6);
                else n_pass++;
            end
        end
    endtask

    task automatic test_auto();
        int pulses = 0;
        drive(0, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 1, 3); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (done === 1'b1) pulses++;
            n_checks++;
            if ({q, busy, done, wraps} !== model_vec())
                $display("FAIL auto_model step=%0d got=%h required=%h", i, {q, busy, done, wraps}, model_vec());
            else n_pass++;
        end
        n_checks++;
        if (pulses != 4 || wraps !== 4'd4 || q !== 4'd0)
            $display("FAIL auto_totals pulses=%0d wraps=%0d q=%0d required 4 4 0", pulses, wraps, q);
        else n_pass++;
    endtask

    task automatic test_saturate();
        drive(0, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if ({q, busy, done, wraps} !== model_vec())
                $display("FAIL sat_model step=%0d got=%h required=%h", i, {q, busy, done, wraps}, model_vec());
            else n_pass++;
        end
        n_checks++;
        if (wraps !== 4'hF || done !== 1'b1 || q !== 4'd0)
            $display("FAIL sat_final wraps=%0d done=%b q=%0d required 15 1 0", wraps, done, q);
        else n_pass++;
    endtask

    task automatic test_pause();
        int pulses = 0;
        drive(0, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 9); tick();
        drive(0, 0, 0, 0, 9);
        for (int i = 0; i < 4; i++) tick();
        drive(0, 1, 0, 0, 9);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== 4'd4 || busy !== 1'b1 || done !== 1'b0 || {q, busy, done, wraps} !== model_vec())
                $display("FAIL pause_hold step=%0d q=%0d busy=%b done=%b required q=4 busy=1 done=0", i, q, busy, done);
            else n_pass++;
        end
        drive(1, 0, 0, 0, 9); tick();
        drive(0, 0, 0, 0, 9);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) pulses++;
            n_checks++;
            if ({q, busy, done, wraps} !== model_vec())
                $display("FAIL pause_resume step=%0d got=%h required=%h", i, {q, busy, done, wraps}, model_vec());
            else n_pass++;
        end
        n_checks++;
        if (pulses != 1 || q !== 4'd9 || busy !== 1'b0)
            $display("FAIL pause_totals pulses=%0d q=%0d busy=%b required 1 9 0", pulses, q, busy);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        drive(0, 0, 1, 0, 0); tick();
        drive(1, 1, 0, 0, 4); tick();
        drive(0, 0, 0, 0, 4); tick();
        n_checks++;
        if (busy !== 1'b0 || q !== 4'd0 || {q, busy, done, wraps} !== model_vec())
            $display("FAIL startstop_idle busy=%b q=%0d required busy=0 q=0", busy, q);
        else n_pass++;
        drive(1, 0, 0, 0, 2); tick();
        drive(0, 0, 0, 0, 2); tick(); tick();
        drive(0, 1, 0, 0, 2); tick(); tick();
        n_checks++;
        if (q !== 4'd2 || busy !== 1'b1 || done !== 1'b0 || {q, busy, done, wraps} !== model_vec())
            $display("FAIL stop_terminal q=%0d busy=%b done=%b required q=2 busy=1 done=0", q, busy, done);
        else n_pass++;
        drive(1, 0, 0, 0, 2); tick();
        drive(0, 0, 0, 0, 2); tick();
        n_checks++;
        if (q !== 4'd2 || busy !== 1'b0 || done !== 1'b1 || {q, busy, done, wraps} !== model_vec())
            $display("FAIL stop_terminal_resume q=%0d busy=%b done=%b required q=2 busy=0 done=1", q, busy, done);
        else n_pass++;
        drive(1, 0, 0, 1, 9); tick();
        drive(0, 0, 0, 1, 9);
        for (int i = 0; i < 6; i++) tick();
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        n_checks++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || {q, busy, done, wraps} !== model_vec())
            $display("FAIL clr_run q=%0d busy=%b done=%b required 0 0 0", q, busy, done);
        else n_pass++;
    endtask

    task automatic test_midrun();
        drive(1, 0, 0, 0, 7); tick();
        drive(0, 0, 0, 1, 2);
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (q !== 4'd7 || done !== 1'b0 || busy !== 1'b1)
            $display("FAIL limit_change_pre q=%0d done=%b busy=%b required 7 0 1", q, done, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (q !== 4'd7 || done !== 1'b1 || busy !== 1'b0 || {q, busy, done, wraps} !== model_vec())
            $display("FAIL limit_change_term q=%0d done=%b busy=%b required 7 1 0", q, done, busy);
        else n_pass++;
        drive(1, 0, 0, 0, 9); tick();
        drive(0, 0, 0, 0, 9); tick(); tick(); tick();
        res = 0; tick();
        res = 1;
        n_checks++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || {q, busy, done, wraps} !== model_vec())
            $display("FAIL reset_midrun q=%0d busy=%b done=%b required 0 0 0", q, busy, done);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            res       = ($urandom_range(0, 59) != 0);
            clr       = ($urandom_range(0, 29) == 0);
            stop      = ($urandom_range(0, 5) == 0);
            start     = ($urandom_range(0, 3) == 0);
            mode_auto = 1'($urandom_range(0, 1));
            limit     = W'($urandom_range(0, QMAX));
            tick();
            n_checks++;
            if ({q, busy, done, wraps} !== model_vec())
                $display("FAIL random step=%0d got=%h required=%h", i, {q, busy, done, wraps}, model_vec());
            else n_pass++;
        end
        res = 1; drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto();
        test_saturate();
        test_pause();
        test_simultaneous();
        test_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
